// File: rtl/mandel_pkg.sv
// Shared definitions for the Mandelbrot iteration engine: FSM state
// encoding, default number format and the 4.0 escape threshold.
package mandel_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int FRAC_W_DEF   = 21;
  localparam int MAX_ITER_DEF = 255;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // 4.0 in the squared-magnitude domain, which carries 2*frac_w fraction bits.
  function automatic logic [127:0] escape_const(input int frac_w);
    return 128'(4) << (2 * frac_w);
  endfunction

endpackage

// File: rtl/mandel_zsq.sv
// Combinational complex square of z: real/imag parts of z^2 rescaled to
// the fixed-point format, plus the full-precision squared magnitude.
module mandel_zsq
  import mandel_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic signed [DATA_W-1:0] zr_i,
  input  logic signed [DATA_W-1:0] zi_i,
  output logic signed [DATA_W-1:0] re_o,
  output logic signed [DATA_W-1:0] im_o,
  output logic        [2*DATA_W:0] mag_o
);

  localparam int PW = 2 * DATA_W;

  logic signed [PW-1:0] zr_x, zi_x, zr2, zi2, diff, dbl;

  // Full-width products; the doubled cross term wraps in the rare corner
  // where both operands are the most negative value.
  always_comb begin
    zr_x  = PW'(zr_i);
    zi_x  = PW'(zi_i);
    zr2   = zr_x * zr_x;
    zi2   = zi_x * zi_x;
    diff  = zr2 - zi2;
    dbl   = (zr_x * zi_x) <<< 1;
    re_o  = DATA_W'(diff >>> FRAC_W);
    im_o  = DATA_W'(dbl >>> FRAC_W);
    mag_o = {1'b0, zr2} + {1'b0, zi2};
  end

endmodule

// File: rtl/mandel_iter.sv
// Mandelbrot escape-time iterator: accepts c and a limit, iterates
// z <= z^2 + c once per cycle and reports divergence and iteration count.
// Optional feature: define MANDEL_PERF_CNT_EN to add the perf_iters
// counter of performed z steps.
//
//   state  | meaning
//   IDLE   | waiting for a request, in_ready=1
//   ITER   | one escape test / z step per cycle
//   DONE   | result held until out_ready
module mandel_iter
  import mandel_pkg::*;
#(
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int FRAC_W   = FRAC_W_DEF,
  parameter  int MAX_ITER = MAX_ITER_DEF,
  localparam int ITER_W   = $clog2(MAX_ITER + 1)
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] c_re,
  input  logic [DATA_W-1:0] c_im,
  input  logic [ITER_W-1:0] iter_limit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              diverged,
  output logic [ITER_W-1:0] iter_count
`ifdef MANDEL_PERF_CNT_EN
  ,
  output logic [31:0]       perf_iters
`endif
);

  localparam int                MAG_W = 2 * DATA_W + 1;
  localparam logic [MAG_W-1:0]  ESC   = MAG_W'(escape_const(FRAC_W));
  localparam logic [ITER_W-1:0] MAX_L = ITER_W'(MAX_ITER);

  state_t                    state_q;
  logic signed [DATA_W-1:0]  zr_q, zi_q, cr_q, ci_q;
  logic        [ITER_W-1:0]  lim_q, n_q, cnt_q;
  logic                      div_q;
  logic signed [DATA_W-1:0]  sq_re, sq_im;
  logic        [MAG_W-1:0]   mag;
  logic        [ITER_W-1:0]  lim_d;
`ifdef MANDEL_PERF_CNT_EN
  logic        [31:0]        perf_q;
`endif

  mandel_zsq #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_zsq (
    .zr_i  (zr_q),
    .zi_i  (zi_q),
    .re_o  (sq_re),
    .im_o  (sq_im),
    .mag_o (mag)
  );

  // Clamp the requested limit to the largest supported value.
  always_comb begin
    lim_d = iter_limit;
    if (int'(iter_limit) > MAX_ITER) lim_d = MAX_L;
  end

  // Request FSM with the z/n datapath and the registered result.
  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q <= S_IDLE;
      zr_q    <= '0;
      zi_q    <= '0;
      cr_q    <= '0;
      ci_q    <= '0;
      lim_q   <= '0;
      n_q     <= '0;
      div_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef MANDEL_PERF_CNT_EN
      perf_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            cr_q    <= c_re;
            ci_q    <= c_im;
            lim_q   <= lim_d;
            zr_q    <= '0;
            zi_q    <= '0;
            n_q     <= '0;
            state_q <= S_ITER;
          end
        end
        S_ITER: begin
          if (mag > ESC) begin
            div_q   <= 1'b1;
            cnt_q   <= n_q;
            state_q <= S_DONE;
          end else if (n_q == lim_q) begin
            div_q   <= 1'b0;
            cnt_q   <= lim_q;
            state_q <= S_DONE;
          end else begin
            zr_q    <= sq_re + cr_q;
            zi_q    <= sq_im + ci_q;
            n_q     <= n_q + 1'b1;
`ifdef MANDEL_PERF_CNT_EN
            perf_q  <= perf_q + 32'd1;
`endif
          end
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign diverged   = div_q;
  assign iter_count = cnt_q;
`ifdef MANDEL_PERF_CNT_EN
  assign perf_iters = perf_q;
`endif

endmodule

// File: tb/tb_mandel_iter.sv
// Self-checking bench for mandel_iter: directed boundary cases plus
// randomized requests, compared every cycle against an arithmetic model.
module tb_mandel_iter;

  localparam int DW   = 32;
  localparam int FW   = 21;
  localparam int IW   = 8;
  localparam int ONE  = 1 << FW;

  logic          aclk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] c_re = '0;
  logic [DW-1:0] c_im = '0;
  logic [IW-1:0] iter_limit = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          diverged;
  logic [IW-1:0] iter_count;
`ifdef MANDEL_PERF_CNT_EN
  logic [31:0]   perf_iters;
`endif

  int checks = 0;
  int failures = 0;

  mandel_iter dut (
    .aclk       (aclk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .c_re       (c_re),
    .c_im       (c_im),
    .iter_limit (iter_limit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diverged   (diverged),
    .iter_count (iter_count)
`ifdef MANDEL_PERF_CNT_EN
    ,
    .perf_iters (perf_iters)
`endif
  );

  initial forever #5 aclk = ~aclk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Escape-time reference: plain integer arithmetic on the fixed-point values.
  task automatic model(input int cr, input int ci, input int lim,
                       output bit dv, output int cnt);
    int zr, zi;
    longint a, b, p;
    logic [64:0] mag;
    logic [64:0] esc;
    zr = 0; zi = 0; dv = 1'b0; cnt = lim;
    esc = 65'd4 << (2 * FW);
    for (int n = 0; n <= lim; n++) begin
      a = longint'(zr) * longint'(zr);
      b = longint'(zi) * longint'(zi);
      mag = {1'b0, a} + {1'b0, b};
      if (mag > esc) begin dv = 1'b1; cnt = n; return; end
      if (n == lim) begin dv = 1'b0; cnt = lim; return; end
      p = longint'(zr) * longint'(zi) * 2;
      zr = int'((a - b) >>> FW) + cr;
      zi = int'(p >>> FW) + ci;
    end
  endtask

  // Cycle-by-cycle checker: tracks the expected request from the bench's
  // own view of acceptance and compares handshake and result outputs.
  initial begin : compare
    bit pend, rst_chk, acc, e_div;
    int cd, e_cnt;
    pend = 0; rst_chk = 0; cd = 0; e_div = 0; e_cnt = 0;
    forever begin
      @(negedge aclk);
      if (rst_chk) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_diverged", diverged, 0);
        chk("rst_iter_count", iter_count, 0);
`ifdef MANDEL_PERF_CNT_EN
        chk("rst_perf_iters", perf_iters, 0);
`endif
        rst_chk = 0;
      end
      if (rst) begin
        pend = 0;
        rst_chk = 1;
      end else begin
        acc = in_valid && !pend;
        if (pend) begin
          if (cd > 0) cd--;
          chk("out_valid", out_valid, (cd == 0) ? 1 : 0);
          chk("in_ready_busy", in_ready, 0);
          if (cd == 0) begin
            chk("diverged", diverged, e_div);
            chk("iter_count", iter_count, e_cnt);
            if (out_ready) pend = 0;
          end
        end else begin
          chk("out_valid_idle", out_valid, 0);
          chk("in_ready_idle", in_ready, 1);
        end
        if (acc) begin
          model(int'(c_re), int'(c_im), int'(iter_limit), e_div, e_cnt);
          cd = e_cnt + 2;
          pend = 1;
        end
      end
    end
  end

  // mode 0: out_ready high, 1: random backpressure, 2: hold DONE 10 cycles
  // with in_valid asserted. Inputs are scrambled once the request is captured.
  task automatic run_req(input int cr, input int ci, input int lim, input int mode);
    int cyc, dv_cnt;
    bit hs;
    c_re = cr; c_im = ci; iter_limit = IW'(lim); in_valid = 1'b1;
    @(posedge aclk); #1;
    cyc = 0; dv_cnt = 0;
    forever begin
      in_valid   = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      c_re       = $urandom;
      c_im       = $urandom;
      iter_limit = IW'($urandom);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) == 0);
        default: out_ready = (dv_cnt >= 10);
      endcase
      @(negedge aclk);
      if (out_valid) dv_cnt++;
      hs = out_valid && out_ready;
      @(posedge aclk); #1;
      cyc++;
      if (hs) break;
      if (cyc > 700) begin
        checks++; failures++;
        $display("FAIL timeout: no result after %0d cycles, expected one", cyc);
        break;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin : stim
    bit dv;
    int cnt;
    // Pin the model to hand-computed results.
    model(0, 0, 100, dv, cnt);
    chk("model_c0_div", dv, 0);   chk("model_c0_cnt", cnt, 100);
    model(2 * ONE, 0, 50, dv, cnt);
    chk("model_c2_div", dv, 1);   chk("model_c2_cnt", cnt, 2);
    model(ONE, 0, 50, dv, cnt);
    chk("model_c1_div", dv, 1);   chk("model_c1_cnt", cnt, 3);
    model(-2 * ONE, 0, 20, dv, cnt);
    chk("model_cm2_div", dv, 0);  chk("model_cm2_cnt", cnt, 20);
    model(0, 0, 0, dv, cnt);
    chk("model_lim0_div", dv, 0); chk("model_lim0_cnt", cnt, 0);

    repeat (3) @(posedge aclk);
    #1 rst = 1'b0;
    @(posedge aclk); #1;

    run_req(0, 0, 100, 0);
    run_req(2 * ONE, 0, 50, 0);
    run_req(ONE, 0, 50, 0);
    run_req(-2 * ONE, 0, 20, 0);
    run_req(0, 0, 0, 0);
    run_req(0, 0, 255, 0);
    run_req(ONE / 4, ONE / 2, 30, 2);

    // Reset while iterating discards the request.
    c_re = 0; c_im = 0; iter_limit = 8'd100; in_valid = 1'b1;
    @(posedge aclk); #1 in_valid = 1'b0;
    repeat (5) @(posedge aclk);
    #1 rst = 1'b1;
    @(posedge aclk); #1 rst = 1'b0;
    @(posedge aclk); #1;
    run_req(2 * ONE, 0, 50, 0);

    // Reset while holding a result.
    c_re = 32'(2 * ONE); c_im = 0; iter_limit = 8'd10; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge aclk); #1 in_valid = 1'b0;
    repeat (8) @(posedge aclk);
    #1 rst = 1'b1;
    @(posedge aclk); #1 rst = 1'b0;
    @(posedge aclk); #1;

    for (int i = 0; i < 40; i++) begin
      int cr, ci;
      if ($urandom_range(0, 7) == 0) begin
        cr = int'($urandom);
        ci = int'($urandom);
      end else begin
        cr = int'($urandom_range(0, 4 * ONE)) - (5 * ONE) / 2;
        ci = int'($urandom_range(0, 3 * ONE)) - (3 * ONE) / 2;
      end
      run_req(cr, ci, int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge aclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mandel_iter.md
MANDEL_ITER -- requirements
Module: mandel_iter

Interface
REQ-001 Parameter DATA_W, default 32: signed two's-complement width of c and z components.
REQ-002 Parameter FRAC_W, default 21: fractional bits of the fixed-point format, so 1.0 = 1<<FRAC_W = 0x00200000.
REQ-003 Parameter MAX_ITER, default 255: largest accepted iteration limit; ITER_W = clog2(MAX_ITER+1).
REQ-004 Port list SHALL be, one per line:
  aclk        in   1       clock; all logic on rising edge
  rst         in   1       synchronous, active-high reset
  in_valid    in   1       request valid
  in_ready    out  1       block idle, can accept a request
  c_re        in   DATA_W  real part of c, signed fixed point
  c_im        in   DATA_W  imaginary part of c, signed fixed point
  iter_limit  in   ITER_W  iteration limit for this request
  out_valid   out  1       result valid
  out_ready   in   1       consumer accepts result
  diverged    out  1       1 = |z|^2 exceeded 4.0 within limit
  iter_count  out  ITER_W  iterations completed at termination
  perf_iters  out  32      present only when MANDEL_PERF_CNT_EN is defined

Function
REQ-005 FSM states: IDLE, ITER, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-006 IDLE: on in_valid=1, capture c_re, c_im, min(iter_limit, MAX_ITER); set z=0, n=0; enter ITER next cycle.
REQ-007 ITER, once per cycle, from the current z: full-precision mag = zr^2 + zi^2 (2*DATA_W+1 bits, unsigned), compared against 4 << (2*FRAC_W).
REQ-008 ITER, divergence: if mag > 4.0 strictly, enter DONE with diverged=1 and iter_count=n.
REQ-009 ITER, limit reached: otherwise, if n == limit, enter DONE with diverged=0 and iter_count=limit.
REQ-010 ITER, step: otherwise z <= (zr^2 - zi^2 + c_re, 2*zr*zi + c_im) and n <= n+1.
REQ-011 Step arithmetic: products are full 2*DATA_W signed, arithmetic-shifted right by FRAC_W, truncated to DATA_W; overflow wraps silently.
REQ-012 Latency: a non-diverging request spends limit+1 cycles in ITER; limit=0 gives iter_count=0, diverged=0 after one ITER cycle.
REQ-013 DONE: diverged and iter_count SHALL hold stable while out_ready=0; on out_ready=1, return to IDLE next cycle.
REQ-014 in_valid outside IDLE SHALL be ignored; input port changes after capture SHALL not affect the running request.

Reset
REQ-015 rst=1 at a clock edge SHALL force IDLE, z=0, n=0, diverged=0, iter_count=0, out_valid=0 (in_ready=1), perf_iters=0.
REQ-016 rst asserted mid-ITER or in DONE SHALL discard the request with no result.

Configuration
REQ-017 Macro MANDEL_PERF_CNT_EN: when defined, perf_iters counts every ITER cycle that performs a z step (REQ-010) and wraps at 2^32; when undefined, the port and the counter are absent and all other behaviour is identical.

Structure
REQ-018 Shared package mandel_pkg SHALL hold the FSM state enum, default DATA_W/FRAC_W, and the function for the 4.0 escape constant.
REQ-019 Sub-module mandel_zsq SHALL be combinational: (zr, zi) in; zr^2-zi^2, 2*zr*zi, zr^2+zi^2 out at the widths above.

Verification
REQ-020 c=(0,0), limit=100 -> diverged=0, iter_count=100, out_valid 101 cycles after ITER entry.
REQ-021 c=(0x00400000,0) [2.0], limit=50 -> z: 0,2,6; diverged=1, iter_count=2.
REQ-022 c=(0x00200000,0) [1.0], limit=50 -> z: 0,1,2,5; diverged=1, iter_count=3; mag=4.0 at n=2 does not diverge.
REQ-023 c=(0xFFC00000,0) [-2.0], limit=20 -> z stays at 2.0, mag=4.0 (boundary); diverged=0, iter_count=20.
REQ-024 out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored; then out_ready=1 -> IDLE next cycle.
REQ-025 rst pulsed at ITER cycle 5 -> IDLE next cycle, all outputs 0, in_ready=1; a new request then completes normally.
